// File: rtl/common.sv
// Shared bus and control types for the core pipeline.
package common;

    typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

    typedef enum logic [3:0] {
        OpNop, OpAdd, OpLd, OpLb, OpLh, OpLw, OpLbu, OpLhu, OpLwu,
        OpSd, OpSb, OpSh, OpSw
    } op_t;

    typedef struct packed {
        op_t  op;
        logic regwrite;
    } ctl_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

// File: rtl/memory_stage_pkg.sv
// Op classification helpers for the memory stage.
package memory_stage_pkg;
    import common::*;

    function automatic logic op_is_load(op_t op);
        return op inside {OpLd, OpLb, OpLh, OpLw, OpLbu, OpLhu, OpLwu};
    endfunction

    function automatic logic op_is_store(op_t op);
        return op inside {OpSd, OpSb, OpSh, OpSw};
    endfunction

    function automatic msize_t op_size(op_t op);
        case (op)
            OpLb, OpLbu, OpSb: return MSIZE1;
            OpLh, OpLhu, OpSh: return MSIZE2;
            OpLw, OpLwu, OpSw: return MSIZE4;
            default:           return MSIZE8;
        endcase
    endfunction

    function automatic logic [3:0] size_bytes(msize_t s);
        case (s)
            MSIZE1:  return 4'd1;
            MSIZE2:  return 4'd2;
            MSIZE4:  return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/pipes.sv
// Pipeline register and forwarding record types.
package pipes;
    import common::*;

    typedef struct packed {
        logic [63:0] pc;
        logic        valid;
        logic [31:0] raw_instr;
        ctl_t        ctl;
        logic [4:0]  dst;
        logic [63:0] rd2;
        logic [63:0] result;
    } excute_data_t;

    typedef struct packed {
        logic [63:0] pc;
        logic        valid;
        logic [31:0] raw_instr;
        ctl_t        ctl;
        logic [4:0]  dst;
        logic [63:0] result;
        logic        misalign;
    } memory_data_t;

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  dst;
        logic        ismem;
    } forward_t;

endpackage

// File: rtl/mem_align.sv
// Combinational size mapping, store alignment and load extraction.
// MEM_MISALIGN_CHECK_EN enables detection of unnaturally aligned accesses.
module mem_align
    import common::*;
    import memory_stage_pkg::*;
(
    input  op_t         op_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] rd2_i,
    input  logic [63:0] rdata_i,
    output logic        is_load_o,
    output logic        is_store_o,
    output msize_t      size_o,
    output logic [7:0]  strobe_o,
    output logic [63:0] wdata_o,
    output logic [63:0] rdata_o,
    output logic        misalign_o
);

    logic [2:0]  off;
    logic [3:0]  nbytes;
    logic [15:0] mask_wide;
    logic [63:0] raw;

    always_comb begin
        off        = addr_i[2:0];
        is_load_o  = op_is_load(op_i);
        is_store_o = op_is_store(op_i);
        size_o     = op_size(op_i);
        nbytes     = size_bytes(size_o);

        // Bytes past lane 7 fall off the bus
        mask_wide = ((16'd1 << nbytes) - 16'd1) << off;
        strobe_o  = is_store_o ? mask_wide[7:0] : 8'h00;
        wdata_o   = rd2_i << {off, 3'b000};

        raw = rdata_i >> {off, 3'b000};
        case (op_i)
            OpLb:    rdata_o = {{56{raw[7]}}, raw[7:0]};
            OpLh:    rdata_o = {{48{raw[15]}}, raw[15:0]};
            OpLw:    rdata_o = {{32{raw[31]}}, raw[31:0]};
            OpLbu:   rdata_o = {56'd0, raw[7:0]};
            OpLhu:   rdata_o = {48'd0, raw[15:0]};
            OpLwu:   rdata_o = {32'd0, raw[31:0]};
            default: rdata_o = raw;
        endcase

`ifdef MEM_MISALIGN_CHECK_EN
        case (size_o)
            MSIZE2:  misalign_o = off[0];
            MSIZE4:  misalign_o = |off[1:0];
            MSIZE8:  misalign_o = |off;
            default: misalign_o = 1'b0;
        endcase
        misalign_o = misalign_o && (is_load_o || is_store_o);
`else
        misalign_o = 1'b0;
`endif
    end

endmodule

// File: rtl/memory_stage.sv
// Memory-access stage: data-bus handshake, upstream stall and writeback register.
// MEM_MISALIGN_CHECK_EN (in mem_align) suppresses misaligned accesses.
module memory_stage
    import common::*;
    import pipes::*;
(
    input  logic         clk,
    input  logic         reset,
    input  excute_data_t dataE,
    output dbus_req_t    dreq,
    input  dbus_resp_t   dresp,
    output logic         stall_m,
    output memory_data_t dataM,
    output forward_t     forward_m
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e       state_q;
    memory_data_t data_m_q;

    logic        is_load, is_store, misalign;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] wdata, rdata_ext;
    logic        req_valid, eff_regwrite;
    logic [63:0] wr_data;

    mem_align u_align (
        .op_i      (dataE.ctl.op),
        .addr_i    (dataE.result),
        .rd2_i     (dataE.rd2),
        .rdata_i   (dresp.data),
        .is_load_o (is_load),
        .is_store_o(is_store),
        .size_o    (size),
        .strobe_o  (strobe),
        .wdata_o   (wdata),
        .rdata_o   (rdata_ext),
        .misalign_o(misalign)
    );

    always_comb begin
        req_valid    = !reset && dataE.valid && (is_load || is_store) && !misalign;
        stall_m      = req_valid && !dresp.data_ok;
        eff_regwrite = dataE.ctl.regwrite && !misalign;
        wr_data      = is_load ? rdata_ext : dataE.result;

        dreq.valid  = req_valid;
        dreq.addr   = dataE.result;
        dreq.size   = size;
        dreq.strobe = strobe;
        dreq.data   = wdata;

        forward_m.data  = wr_data;
        forward_m.dst   = (!reset && eff_regwrite && dataE.valid) ? dataE.dst : 5'd0;
        // Consumer must hold until the load data actually arrives
        forward_m.ismem = stall_m && is_load;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= StIdle;
            data_m_q.valid    <= 1'b0;
            data_m_q.misalign <= 1'b0;
        end else begin
            case (state_q)
                StIdle:  if (stall_m) state_q <= StWait;
                StWait:  if (dresp.data_ok) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase

            if (stall_m) begin
                data_m_q.valid <= 1'b0;
            end else begin
                data_m_q.pc           <= dataE.pc;
                data_m_q.valid        <= dataE.valid;
                data_m_q.raw_instr    <= dataE.raw_instr;
                data_m_q.ctl.op       <= dataE.ctl.op;
                data_m_q.ctl.regwrite <= eff_regwrite;
                data_m_q.dst          <= dataE.dst;
                data_m_q.result       <= wr_data;
                data_m_q.misalign     <= dataE.valid && misalign;
            end
        end
    end

    assign dataM = data_m_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios then randomized transactions.
module tb_memory_stage;
    import common::*;
    import pipes::*;

    logic         clk = 1'b0;
    logic         reset;
    excute_data_t dataE;
    dbus_req_t    dreq;
    dbus_resp_t   dresp;
    logic         stall_m;
    memory_data_t dataM;
    forward_t     forward_m;

    int vectors = 0;
    int miscompares = 0;

    memory_stage dut (
        .clk      (clk),
        .reset    (reset),
        .dataE    (dataE),
        .dreq     (dreq),
        .dresp    (dresp),
        .stall_m  (stall_m),
        .dataM    (dataM),
        .forward_m(forward_m)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int ref_bytes(op_t op);
        case (op)
            OpLb, OpLbu, OpSb: return 1;
            OpLh, OpLhu, OpSh: return 2;
            OpLw, OpLwu, OpSw: return 4;
            default:           return 8;
        endcase
    endfunction

    function automatic msize_t ref_size(int nb);
        case (nb)
            1:       return MSIZE1;
            2:       return MSIZE2;
            4:       return MSIZE4;
            default: return MSIZE8;
        endcase
    endfunction

    function automatic logic [63:0] ref_load(op_t op, logic [63:0] raw);
        logic [63:0] v;
        case (op)
            OpLb:  begin v = raw & 64'hFF;       if (raw[7])  v = v | ~64'hFF;       end
            OpLh:  begin v = raw & 64'hFFFF;     if (raw[15]) v = v | ~64'hFFFF;     end
            OpLw:  begin v = raw & 64'hFFFFFFFF; if (raw[31]) v = v | ~64'hFFFFFFFF; end
            OpLbu: v = raw & 64'hFF;
            OpLhu: v = raw & 64'hFFFF;
            OpLwu: v = raw & 64'hFFFFFFFF;
            default: v = raw;
        endcase
        return v;
    endfunction

    // Entered just after a rising edge; returns just after the edge that captures the result.
    task automatic txn(input op_t op, input logic [63:0] addr, input logic [63:0] rd2,
                       input logic [63:0] rdata, input logic rw, input logic [4:0] dst,
                       input int nwait);
        logic        ld, st, mis, req;
        int          nb, off, m;
        logic [7:0]  es;
        logic [63:0] ed, ewr, pc;
        logic [31:0] ri;
        int          nw;

        ld  = op inside {OpLd, OpLb, OpLh, OpLw, OpLbu, OpLhu, OpLwu};
        st  = op inside {OpSd, OpSb, OpSh, OpSw};
        nb  = ref_bytes(op);
        off = int'(addr[2:0]);
`ifdef MEM_MISALIGN_CHECK_EN
        mis = (ld || st) && (off % nb) != 0;
`else
        mis = 1'b0;
`endif
        req = (ld || st) && !mis;
        nw  = req ? nwait : 0;
        m   = ((1 << nb) - 1) << off;
        es  = st ? m[7:0] : 8'h00;
        ed  = rd2 << (8 * off);
        ewr = ld ? ref_load(op, rdata >> (8 * off)) : addr;
        pc  = {32'd0, $urandom};
        ri  = $urandom;

        dataE.pc           = pc;
        dataE.valid        = 1'b1;
        dataE.raw_instr    = ri;
        dataE.ctl.op       = op;
        dataE.ctl.regwrite = rw;
        dataE.dst          = dst;
        dataE.rd2          = rd2;
        dataE.result       = addr;

        for (int i = 0; i < nw; i++) begin
            dresp.data_ok = 1'b0;
            dresp.data    = {$urandom, $urandom};
            #1;
            chk("wait_stall", 64'(stall_m), 64'd1);
            chk("wait_dreq_valid", 64'(dreq.valid), 64'd1);
            chk("wait_ismem", 64'(forward_m.ismem), 64'(ld));
            @(posedge clk); #1;
            chk("bubble_valid", 64'(dataM.valid), 64'd0);
        end

        dresp.data_ok = 1'b1;
        dresp.data    = rdata;
        #1;
        chk("stall", 64'(stall_m), 64'd0);
        chk("dreq_valid", 64'(dreq.valid), 64'(req));
        if (req) begin
            chk("dreq_addr", dreq.addr, addr);
            chk("dreq_size", 64'(dreq.size), 64'(ref_size(nb)));
            chk("dreq_strobe", 64'(dreq.strobe), 64'(es));
            if (st) chk("dreq_data", dreq.data, ed);
        end
        chk("fwd_data", forward_m.data, ewr);
        chk("fwd_dst", 64'(forward_m.dst), (rw && !mis) ? 64'(dst) : 64'd0);
        chk("fwd_ismem", 64'(forward_m.ismem), 64'd0);
        @(posedge clk); #1;
        chk("m_valid", 64'(dataM.valid), 64'd1);
        chk("m_result", dataM.result, ewr);
        chk("m_pc", dataM.pc, pc);
        chk("m_instr", 64'(dataM.raw_instr), 64'(ri));
        chk("m_dst", 64'(dataM.dst), 64'(dst));
        chk("m_regwrite", 64'(dataM.ctl.regwrite), 64'(rw && !mis));
        chk("m_misalign", 64'(dataM.misalign), 64'(mis));
        dresp.data_ok = 1'b0;
    endtask

    initial begin
        op_t         op;
        logic [63:0] addr;
        logic        ld;

        // Reset with a valid load presented: the request must be gated
        reset = 1'b1;
        dataE = '0;
        dataE.valid = 1'b1;
        dataE.ctl.op = OpLd;
        dataE.ctl.regwrite = 1'b1;
        dataE.dst = 5'd7;
        dataE.result = 64'h2000;
        dresp = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_m_valid", 64'(dataM.valid), 64'd0);
        chk("rst_stall", 64'(stall_m), 64'd0);
        chk("rst_dreq_valid", 64'(dreq.valid), 64'd0);
        chk("rst_fwd_dst", 64'(forward_m.dst), 64'd0);
        reset = 1'b0;
        dataE.valid = 1'b0;
        @(posedge clk); #1;

        txn(OpSw, 64'h1004, 64'h1122334455667788, 64'h0, 1'b0, 5'd0, 0);
        txn(OpLb, 64'h1003, 64'h0, 64'h0000000080000000, 1'b1, 5'd3, 3);
        txn(OpLbu, 64'h1003, 64'h0, 64'h0000000080000000, 1'b1, 5'd4, 3);
        txn(OpAdd, 64'h2A, 64'h0, 64'h0, 1'b1, 5'd5, 0);
        txn(OpLw, 64'h1002, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b1, 5'd6, 1);

        // Reset arriving while an LD waits on the bus
        dataE.valid = 1'b1;
        dataE.ctl.op = OpLd;
        dataE.ctl.regwrite = 1'b1;
        dataE.dst = 5'd9;
        dataE.result = 64'h3000;
        dresp.data_ok = 1'b0;
        #1;
        chk("ldw_stall", 64'(stall_m), 64'd1);
        @(posedge clk); #1;
        chk("ldw_bubble", 64'(dataM.valid), 64'd0);
        reset = 1'b1;
        #1;
        chk("ldw_rst_stall", 64'(stall_m), 64'd0);
        chk("ldw_rst_dreq", 64'(dreq.valid), 64'd0);
        @(posedge clk); #1;
        chk("ldw_rst_m_valid", 64'(dataM.valid), 64'd0);
        reset = 1'b0;
        dataE.valid = 1'b0;
        dresp.data_ok = 1'b1;
        dresp.data = 64'h1234;
        #1;
        chk("late_ok_stall", 64'(stall_m), 64'd0);
        chk("late_ok_dreq", 64'(dreq.valid), 64'd0);
        chk("late_ok_fwd_dst", 64'(forward_m.dst), 64'd0);
        @(posedge clk); #1;
        chk("late_ok_m_valid", 64'(dataM.valid), 64'd0);
        dresp.data_ok = 1'b0;

        for (int n = 0; n < 300; n++) begin
            op   = op_t'($urandom_range(0, 12));
            addr = {48'd0, 16'($urandom)};
            ld   = op inside {OpLd, OpLb, OpLh, OpLw, OpLbu, OpLhu, OpLwu};
            txn(op, addr, {$urandom, $urandom}, {$urandom, $urandom},
                ld ? 1'b1 : ((op == OpAdd) ? 1'($urandom) : 1'b0),
                5'($urandom_range(1, 31)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
